// File: rtl/led_word_serializer_pkg.sv
// Shared types and defaults for the LED word serializer.
package led_word_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int LED_BIT_TICKS = 1251;

endpackage

// File: rtl/led_word_serializer_tick.sv
// End-of-bit-period strobe generator.
module bit_tick_gen
  import led_word_serializer_pkg::*;
#(
  parameter int BIT_TICKS = LED_BIT_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(BIT_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(BIT_TICKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/led_word_serializer.sv
// Shifts a framed word out on one LED pin, LSB first.
module led_word_serializer
  import led_word_serializer_pkg::*;
#(
  parameter int   WIDTH     = 48,
  parameter int   BIT_TICKS = LED_BIT_TICKS,
  parameter logic IDLE_LVL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             led,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [IW-1:0]    bidx, bidx_n;
  logic             led_n;
  logic             done_n;
  logic             tick;
  logic             accept;

  assign in_ready = (state == ST_IDLE);
  assign busy     = !in_ready;
  assign accept   = in_valid && in_ready;

  // Counter is held at zero while idle, so it restarts on accept.
  bit_tick_gen #(
    .BIT_TICKS(BIT_TICKS)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (in_ready),
    .tick (tick)
  );

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bidx_n  = bidx;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          shreg_n = in_data;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (tick) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shreg_n = shreg >> 1;
          if (bidx == LAST_BIT) begin
            bidx_n  = '0;
            state_n = ST_STOP;
          end else begin
            bidx_n = bidx + IW'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // led is registered from the next state so it lines up with state.
  always_comb begin
    led_n = IDLE_LVL;
    unique case (state_n)
      ST_START: led_n = ~IDLE_LVL;
      ST_DATA:  led_n = shreg_n[0];
      default:  led_n = IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      shreg <= '0;
      bidx  <= '0;
      led   <= IDLE_LVL;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      bidx  <= bidx_n;
      led   <= led_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_led_word_serializer.sv
// Directed bench for led_word_serializer.
module tb_led_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst1_n;
  logic [47:0] in_data, in_data1;
  logic        in_valid, in_valid1;
  logic        in_ready, led, busy, done;
  logic        in_ready1, led1, busy1, done1;

  int checks = 0;
  int failures = 0;

  led_word_serializer #(
    .WIDTH(48), .BIT_TICKS(4), .IDLE_LVL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .led(led), .busy(busy), .done(done)
  );

  led_word_serializer #(
    .WIDTH(48), .BIT_TICKS(1), .IDLE_LVL(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst1_n), .in_data(in_data1),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .led(led1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send0(input logic [47:0] d);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Samples n=0..200 after the accept edge (BIT_TICKS=4).
  task automatic capture0(output logic [47:0] w, output int bad,
                          output int done_at, output int ndone,
                          output logic rdy_end);
    logic l [0:200];
    logic d [0:200];
    logic e;
    rdy_end = 1'b0;
    for (int n = 0; n <= 200; n++) begin
      @(negedge clk);
      l[n] = led;
      d[n] = done;
      if (n == 200) rdy_end = in_ready;
    end
    for (int i = 0; i < 48; i++) w[i] = l[4 + 4*i];
    bad = 0;
    for (int p = 0; p < 50; p++) begin
      for (int j = 0; j < 4; j++) begin
        e = (p == 0) ? 1'b1 : (p == 49) ? 1'b0 : w[p-1];
        if (l[4*p + j] !== e) bad++;
      end
    end
    done_at = -1;
    ndone = 0;
    for (int n = 0; n <= 200; n++) begin
      if (d[n] === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = n;
      end
    end
  endtask

  int bad, done_at, ndone, bad2, done_at2, ndone2;
  logic rdy_end, rdy_end2;
  logic [47:0] w, w2;

  initial begin
    // 1: reset, valid held high during reset
    rst_n = 1'b0; rst1_n = 1'b0;
    in_data = 48'h0000_0000_00AA; in_valid = 1'b1;
    in_data1 = '0; in_valid1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", 64'(led), 64'(1'b0));
    chk("rst_ready", 64'(in_ready), 64'(1'b1));
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_done", 64'(done), 64'(1'b0));
    chk("rst_led1", 64'(led1), 64'(1'b1));
    chk("rst_ready1", 64'(in_ready1), 64'(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1; rst1_n = 1'b1;
    @(negedge clk);
    chk("rst_noaccept", 64'(busy), 64'(1'b0));

    // 2: single frame
    send0(48'h007F_FF3C_F7D7);
    chk("t2_busy", 64'(busy), 64'(1'b1));
    chk("t2_ready", 64'(in_ready), 64'(1'b0));
    capture0(w, bad, done_at, ndone, rdy_end);
    chk("t2_bits", 64'(w[7:0]), 64'(8'hD7));
    chk("t2_word", 64'(w), 64'(48'h007F_FF3C_F7D7));
    chk("t2_shape", 64'(bad), 64'(0));
    chk("t2_done_at", 64'(done_at), 64'(200));
    chk("t2_ndone", 64'(ndone), 64'(1));
    chk("t2_ready_end", 64'(rdy_end), 64'(1'b1));

    // 3: back-to-back with valid held
    @(negedge clk);
    in_data = 48'h0000_0000_0001;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data = 48'hFFFF_FFFF_FFFF;
    capture0(w, bad, done_at, ndone, rdy_end);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t3_accept2", 64'(busy), 64'(1'b1));
    capture0(w2, bad2, done_at2, ndone2, rdy_end2);
    chk("t3_word1", 64'(w), 64'(48'h0000_0000_0001));
    chk("t3_shape1", 64'(bad), 64'(0));
    chk("t3_done1", 64'(done_at), 64'(200));
    chk("t3_ready1", 64'(rdy_end), 64'(1'b1));
    chk("t3_word2", 64'(w2), 64'(48'hFFFF_FFFF_FFFF));
    chk("t3_shape2", 64'(bad2), 64'(0));
    chk("t3_done2", 64'(done_at2), 64'(200));

    // 4: word presented mid-frame is ignored
    send0(48'h0F0F_1234_5678);
    fork
      capture0(w, bad, done_at, ndone, rdy_end);
      begin
        repeat (50) @(negedge clk);
        in_data = 48'hFFFF_0000_FFFF;
        in_valid = 1'b1;
        repeat (40) @(negedge clk);
        chk("t4_ready_low", 64'(in_ready), 64'(1'b0));
        in_valid = 1'b0;
      end
    join
    chk("t4_word", 64'(w), 64'(48'h0F0F_1234_5678));
    chk("t4_shape", 64'(bad), 64'(0));
    chk("t4_done_at", 64'(done_at), 64'(200));
    @(negedge clk);
    chk("t4_idle", 64'(busy), 64'(1'b0));

    // 5: reset during data bit 20
    send0(48'hDEAD_BEEF_CAFE);
    repeat (85) @(negedge clk);
    chk("t5_pre_busy", 64'(busy), 64'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_led", 64'(led), 64'(1'b0));
    chk("t5_busy", 64'(busy), 64'(1'b0));
    chk("t5_ready", 64'(in_ready), 64'(1'b1));
    ndone = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 210; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    chk("t5_no_done", 64'(ndone), 64'(0));
    send0(48'h1234_5678_9ABC);
    capture0(w, bad, done_at, ndone, rdy_end);
    chk("t5_word", 64'(w), 64'(48'h1234_5678_9ABC));
    chk("t5_shape", 64'(bad), 64'(0));
    chk("t5_done_at", 64'(done_at), 64'(200));

    // 6: BIT_TICKS=1, IDLE_LVL=1
    @(negedge clk);
    in_data1 = 48'hA5A5_0F0F_C3C3;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    bad = 0; done_at = -1; ndone = 0;
    for (int n = 0; n <= 50; n++) begin
      @(negedge clk);
      if (n == 0 && led1 !== 1'b0) bad++;
      if (n >= 1 && n <= 48) w[n-1] = led1;
      if (n >= 49 && led1 !== 1'b1) bad++;
      if (done1 === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = n;
      end
    end
    chk("t6_word", 64'(w), 64'(48'hA5A5_0F0F_C3C3));
    chk("t6_levels", 64'(bad), 64'(0));
    chk("t6_done_at", 64'(done_at), 64'(50));
    chk("t6_ndone", 64'(ndone), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
